// File: rtl/ej32_mem_arb.sv
// ej32_mem_arb: shares one byte-wide synchronous memory port between
// instruction fetch (single bytes) and the load/store unit (1/2/4-byte
// big-endian transfers), serialising LS transfers into back-to-back byte
// cycles and alternating the grant when both sides contend.
module ej32_mem_arb #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_vld,
  output logic [7:0]    if_data,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_len,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic [31:0]   ls_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic {IDLE, LS_BUSY} state_t;
  typedef enum logic {REQ_LS, REQ_IF} req_t;

  state_t        state, state_nxt;
  req_t          last, last_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [1:0]    last_idx_r;   // index of the final byte (N-1)
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;      // remaining write bytes, next one in [31:24]
  logic [31:0]   ls_wdata_al;
  logic          issue_rd;
  logic          issue_last;
  logic          if_vld_p1;
  logic          rd_vld_p1;
  logic          done_p1;
  logic [31:0]   rdata_p1;

  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Left-align the active bytes so the first byte sent sits in [31:24].
  function automatic logic [31:0] align_wdata(input logic [1:0] len, input logic [31:0] wd);
    case (len)
      2'd0:    return {wd[7:0], 24'h000000};
      2'd1:    return {wd[15:0], 16'h0000};
      default: return wd;
    endcase
  endfunction

  assign ls_wdata_al = align_wdata(ls_len, ls_wdata);

  // Arbitration, byte sequencing and memory-port drive; all forced idle in reset.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    cnt_nxt    = cnt;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    issue_rd   = 1'b0;
    issue_last = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (ls_req && (!if_req || last == REQ_IF)) begin
            ls_gnt    = 1'b1;
            mem_cs    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_we ? ls_wdata_al[31:24] : 8'h00;
            issue_rd  = !ls_we;
            last_nxt  = REQ_LS;
            if (last_idx(ls_len) == 2'd0) begin
              issue_last = 1'b1;
            end else begin
              state_nxt = LS_BUSY;
              cnt_nxt   = 2'd1;
            end
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_cs   = 1'b1;
            mem_addr = if_addr;
            last_nxt = REQ_IF;
          end
        end
        LS_BUSY: begin
          mem_cs    = 1'b1;
          mem_we    = we_r;
          mem_addr  = addr_r + AW'(cnt);
          mem_wdata = we_r ? wdata_r[31:24] : 8'h00;
          issue_rd  = !we_r;
          if (cnt == last_idx_r) begin
            issue_last = 1'b1;
            state_nxt  = IDLE;
            cnt_nxt    = 2'd0;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= REQ_LS;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Transfer parameters captured at LS grant; write bytes shift out MSB first.
  always_ff @(posedge clk) begin
    if (ls_gnt) begin
      last_idx_r <= last_idx(ls_len);
      we_r       <= ls_we;
      addr_r     <= ls_addr;
      wdata_r    <= ls_wdata_al << 8;
    end else if (state == LS_BUSY) begin
      wdata_r <= wdata_r << 8;
    end
  end

  // ---- p1: response stage, one cycle behind the memory byte cycle ----
  // Fetch valid, read-byte accumulation and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
      done_p1   <= 1'b0;
      rdata_p1  <= 32'h0;
    end else begin
      if_vld_p1 <= if_gnt;
      rd_vld_p1 <= issue_rd;
      done_p1   <= issue_last;
      if (ls_gnt) begin
        rdata_p1 <= 32'h0;
      end else if (rd_vld_p1) begin
        rdata_p1 <= {rdata_p1[23:0], mem_rdata};
      end
    end
  end

  // The RAM byte arrives in the response cycle, so it is merged on the way out
  // to make the assembled word visible together with ls_done / if_vld.
  assign if_vld   = if_vld_p1;
  assign if_data  = if_vld_p1 ? mem_rdata : 8'h00;
  assign ls_done  = done_p1;
  assign ls_rdata = rd_vld_p1 ? {rdata_p1[23:0], mem_rdata} : rdata_p1;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Self-checking bench for ej32_mem_arb: directed reset/fetch/contention/abort
// sequences, a table of LS transfers, and a randomized phase checked against a
// transaction-level model of the memory port.
module tb_ej32_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt, if_vld;
  logic [7:0]  if_data;
  logic        ls_req, ls_we;
  logic [1:0]  ls_len;
  logic [15:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt, ls_done;
  logic [31:0] ls_rdata;
  logic        mem_cs, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ej32_mem_arb #(.AW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_vld(if_vld), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous byte RAM with directed-test contents preloaded.
  logic [7:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h0010] = 8'hA0; ram[16'h0011] = 8'hA1; ram[16'h0012] = 8'hA2;
    ram[16'h0100] = 8'h12; ram[16'h0101] = 8'h34; ram[16'h0102] = 8'h56; ram[16'h0103] = 8'h78;
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;
    ram[16'h0005] = 8'h9C;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_cs) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 16'h0; ls_req = 1'b0; ls_we = 1'b0;
    ls_len = 2'd0; ls_addr = 16'h0; ls_wdata = 32'h0;
  endtask

  // Two reset posedges; returns just after a posedge with rst released.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } ls_vec_t;

  ls_vec_t vecs[9];

  // One isolated LS transfer: grant and byte stream, then done at T+lat.
  task automatic run_ls(input int k, input ls_vec_t v);
    logic [15:0] a;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = v.we; ls_len = v.len; ls_addr = v.addr; ls_wdata = v.wdata;
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      a = v.addr + 16'(i);
      chk1($sformatf("v%0d_gnt%0d", k, i), ls_gnt, (i == 0));
      chk1($sformatf("v%0d_cs%0d", k, i), mem_cs, 1'b1);
      chk1($sformatf("v%0d_we%0d", k, i), mem_we, v.we);
      chk($sformatf("v%0d_addr%0d", k, i), 32'(mem_addr), 32'(a));
      if (v.we)
        chk($sformatf("v%0d_wdata%0d", k, i), 32'(mem_wdata), 32'(8'(v.wdata >> (8 * (v.lat - 1 - i)))));
      chk1($sformatf("v%0d_done_early%0d", k, i), ls_done, 1'b0);
      if (i == 0) begin
        @(posedge clk); #1 ls_req = 1'b0;
      end
    end
    @(negedge clk);
    chk1($sformatf("v%0d_done", k), ls_done, 1'b1);
    chk($sformatf("v%0d_rdata", k), ls_rdata, v.rdata);
    chk1($sformatf("v%0d_busy_end", k), busy, 1'b0);
    @(negedge clk);
    chk1($sformatf("v%0d_done_pulse", k), ls_done, 1'b0);
    chk($sformatf("v%0d_rdata_held", k), ls_rdata, v.rdata);
  endtask

  // Reference model state for the randomized phase.
  typedef struct packed {
    logic [15:0] a;
    logic        we;
    logic [7:0]  d;
  } bus_t;

  logic [7:0] ref_mem [0:65535];
  bus_t       bus_q[$];
  int         cyc;
  int         done_cyc, ifv_cyc;
  logic [31:0] done_exp;
  logic [7:0]  ifv_exp;
  logic        prev_if;      // 1 when the most recent grant went to fetch
  logic        ls_granted;

  function automatic logic [15:0] rnd_addr();
    return 16'hFFE0 + 16'($urandom_range(0, 63));
  endfunction

  task automatic chk_bus_front();
    bus_t e;
    e = bus_q.pop_front();
    chk1("rnd_cs", mem_cs, 1'b1);
    chk1("rnd_we", mem_we, e.we);
    chk("rnd_addr", 32'(mem_addr), 32'(e.a));
    if (e.we) chk("rnd_wdata", 32'(mem_wdata), 32'(e.d));
  endtask

  task automatic monitor();
    logic exp_ls, exp_if;
    logic [31:0] rd;
    logic [15:0] a;
    logic [7:0]  b;
    int n;
    chk1("rnd_done", ls_done, (cyc == done_cyc));
    if (cyc == done_cyc) chk("rnd_rdata", ls_rdata, done_exp);
    chk1("rnd_ifvld", if_vld, (cyc == ifv_cyc));
    if (cyc == ifv_cyc) chk("rnd_ifdata", 32'(if_data), 32'(ifv_exp));
    ls_granted = 1'b0;
    if (bus_q.size() > 0) begin
      chk1("rnd_busy", busy, 1'b1);
      chk1("rnd_no_ifgnt", if_gnt, 1'b0);
      chk1("rnd_no_lsgnt", ls_gnt, 1'b0);
      chk_bus_front();
    end else begin
      chk1("rnd_idle", busy, 1'b0);
      exp_ls = ls_req && (!if_req || prev_if);
      exp_if = !exp_ls && if_req;
      chk1("rnd_ifgnt", if_gnt, exp_if);
      chk1("rnd_lsgnt", ls_gnt, exp_ls);
      if (exp_ls) begin
        n  = (ls_len == 2'd0) ? 1 : (ls_len == 2'd1) ? 2 : 4;
        rd = 32'h0;
        for (int i = 0; i < n; i++) begin
          a = ls_addr + 16'(i);
          if (ls_we) begin
            b = 8'(ls_wdata >> (8 * (n - 1 - i)));
            ref_mem[a] = b;
          end else begin
            b  = ref_mem[a];
            rd = (rd << 8) | 32'(b);
          end
          bus_q.push_back('{a: a, we: ls_we, d: b});
        end
        chk_bus_front();
        done_cyc   = cyc + n;
        done_exp   = ls_we ? 32'h0 : rd;
        prev_if    = 1'b0;
        ls_granted = 1'b1;
      end else if (exp_if) begin
        chk1("rnd_if_cs", mem_cs, 1'b1);
        chk1("rnd_if_we", mem_we, 1'b0);
        chk("rnd_if_addr", 32'(mem_addr), 32'(if_addr));
        ifv_cyc = cyc + 1;
        ifv_exp = ref_mem[if_addr];
        prev_if = 1'b1;
      end else begin
        chk1("rnd_quiet_cs", mem_cs, 1'b0);
      end
    end
    cyc++;
  endtask

  initial begin
    vecs[0] = '{we: 1'b0, len: 2'd2, addr: 16'h0100, wdata: 32'h0,        rdata: 32'h12345678, lat: 4};
    vecs[1] = '{we: 1'b1, len: 2'd1, addr: 16'h0200, wdata: 32'hDEADBEEF, rdata: 32'h0,        lat: 2};
    vecs[2] = '{we: 1'b0, len: 2'd1, addr: 16'h0200, wdata: 32'h0,        rdata: 32'h0000BEEF, lat: 2};
    vecs[3] = '{we: 1'b0, len: 2'd2, addr: 16'hFFFE, wdata: 32'h0,        rdata: 32'h11223344, lat: 4};
    vecs[4] = '{we: 1'b0, len: 2'd0, addr: 16'h0005, wdata: 32'h0,        rdata: 32'h0000009C, lat: 1};
    vecs[5] = '{we: 1'b1, len: 2'd3, addr: 16'h0300, wdata: 32'hCAFEF00D, rdata: 32'h0,        lat: 4};
    vecs[6] = '{we: 1'b0, len: 2'd3, addr: 16'h0300, wdata: 32'h0,        rdata: 32'hCAFEF00D, lat: 4};
    vecs[7] = '{we: 1'b1, len: 2'd0, addr: 16'h0400, wdata: 32'h12345699, rdata: 32'h0,        lat: 1};
    vecs[8] = '{we: 1'b0, len: 2'd0, addr: 16'h0400, wdata: 32'h0,        rdata: 32'h00000099, lat: 1};

    // Reset with both requests high: grants and memory strobes must stay low.
    rst = 1'b0;
    idle_inputs();
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_mem_cs", mem_cs, 1'b0);
    @(posedge clk); #1 ls_req = 1'b1; ls_addr = 16'h0100;
    @(negedge clk);
    chk1("rst_ls_gnt", ls_gnt, 1'b0);
    chk1("rst_mem_cs2", mem_cs, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_vld", if_vld, 1'b0);
    chk1("rst_ls_done", ls_done, 1'b0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_if_data", 32'(if_data), 32'h0);
    chk1("rst_idle_cs", mem_cs, 1'b0);

    // Back-to-back fetches, one per cycle.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0010 + 16'(k);
      @(negedge clk);
      chk1($sformatf("if%0d_gnt", k), if_gnt, 1'b1);
      chk1($sformatf("if%0d_cs", k), mem_cs, 1'b1);
      chk1($sformatf("if%0d_we", k), mem_we, 1'b0);
      chk($sformatf("if%0d_addr", k), 32'(mem_addr), 32'h10 + 32'(k));
      chk1($sformatf("if%0d_busy", k), busy, 1'b0);
      if (k > 0) begin
        chk1($sformatf("if%0d_vld", k), if_vld, 1'b1);
        chk($sformatf("if%0d_data", k), 32'(if_data), 32'hA0 + 32'(k - 1));
      end
    end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    chk1("if_last_vld", if_vld, 1'b1);
    chk("if_last_data", 32'(if_data), 32'hA2);
    chk1("if_after_gnt", if_gnt, 1'b0);
    @(negedge clk);
    chk1("if_vld_clear", if_vld, 1'b0);

    // Table of isolated LS transfers.
    foreach (vecs[k]) run_ls(k, vecs[k]);

    // Contention from reset: IF first, then strict alternation.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0011;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'd0; ls_addr = 16'h0005;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1($sformatf("cont%0d_if", k), if_gnt, (k % 2 == 0));
      chk1($sformatf("cont%0d_ls", k), ls_gnt, (k % 2 == 1));
      chk($sformatf("cont%0d_addr", k), 32'(mem_addr), (k % 2 == 0) ? 32'h11 : 32'h05);
      if (k > 0) chk1($sformatf("cont%0d_ifvld", k), if_vld, (k % 2 == 1));
      if (k > 1) chk1($sformatf("cont%0d_done", k), ls_done, (k % 2 == 0));
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset in the cnt==2 cycle of a 4-byte read aborts it silently.
    #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'd2; ls_addr = 16'h0100;
    @(negedge clk);
    chk1("abort_gnt", ls_gnt, 1'b1);
    @(posedge clk); #1 ls_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("abort_cs", mem_cs, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk1("abort_no_done", ls_done, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_no_cs", mem_cs, 1'b0);
    chk("abort_rdata", ls_rdata, 32'h0);
    @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0012;
    @(negedge clk);
    chk1("abort_no_done2", ls_done, 1'b0);
    chk1("abort_if_gnt", if_gnt, 1'b1);
    chk("abort_if_addr", 32'(mem_addr), 32'h12);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    chk1("abort_if_vld", if_vld, 1'b1);
    chk("abort_if_data", 32'(if_data), 32'hA2);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];
    cyc = 0; done_cyc = -1; ifv_cyc = -1; prev_if = 1'b0; ls_granted = 1'b0;
    done_exp = 32'h0; ifv_exp = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (c < 2950) begin
        if (ls_req && ls_granted) ls_req = 1'b0;
        else if (ls_req && $urandom_range(0, 15) == 0) ls_req = 1'b0;
        if (!ls_req && $urandom_range(0, 2) == 0) begin
          ls_req   = 1'b1;
          ls_we    = 1'($urandom_range(0, 1));
          ls_len   = 2'($urandom_range(0, 3));
          ls_addr  = rnd_addr();
          ls_wdata = $urandom;
        end
        if_req  = 1'($urandom_range(0, 1));
        if_addr = rnd_addr();
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
    end
    chk("rnd_drained", 32'(bus_q.size()), 32'h0);
    begin
      int bad = 0;
      for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) bad++;
      chk("mem_image", 32'(bad), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
- Arbiter and sequencer for the single byte-wide memory port. It is shared by instruction fetch (IF, one opcode/operand byte per request) and the load/store unit (LS, 1/2/4-byte big-endian transfers used by iaload/saload/baload/iastore/sastore/bastore/get/put).
- Converts multi-byte LS transfers into back-to-back byte cycles.
- Alternates the grant when both sides contend, so a stream of LS ops cannot starve the decoder.

Parameters:
- AW, 16, memory byte-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- if_req  in  1  fetch request, level.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch issued this cycle (combinational).
- if_vld  out  1  if_data valid; registered, exactly 1 cycle after if_gnt.
- if_data  out  8  fetched byte.
- ls_req  in  1  LS request; held high until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 and 3 = 4 bytes.
- ls_addr  in  AW  first (most-significant) byte address.
- ls_wdata  in  32  write data, right-aligned.
- ls_gnt  out  1  LS transfer accepted this cycle (combinational); inputs are sampled here.
- ls_done  out  1  one-cycle pulse when the transfer is complete.
- ls_rdata  out  32  read result, zero-extended, valid with ls_done and held until the next ls_gnt.
- mem_cs  out  1  memory byte cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte; synchronous RAM, valid the cycle after mem_cs with !mem_we.
- busy  out  1  state != IDLE.

Behaviour:
Reset
- While rst==0: mem_cs, mem_we, if_gnt and ls_gnt are forced 0 combinationally.
- At the posedge: state=IDLE, cnt=0, last=LS (so IF wins the first contention), and if_vld, ls_done, ls_rdata, if_data are all 0.
- Reset mid-transfer aborts it. No ls_done is issued, and no further memory cycles occur after the reset posedge.

FSM states: IDLE and LS_BUSY.

IDLE, evaluated each cycle
- Grant LS if ls_req && (!if_req || last==IF). Otherwise grant IF if if_req. Otherwise idle; all mem_* outputs are 0.
- IF grant:
  - Cycle T: if_gnt=1, mem_cs=1, mem_we=0, mem_addr=if_addr, last<=IF.
  - T+1: if_vld=1 and if_data=mem_rdata.
  - Stay in IDLE. Back-to-back fetches run 1 per cycle.
- LS grant:
  - Cycle T: ls_gnt=1 and byte 0 is issued at ls_addr.
  - Latch N = 1/2/4, we, addr, and wdata left-aligned so that byte 0 is the MSB of the active bytes. For N=2 the first byte is wdata[15:8]; for N=1 it is wdata[7:0].
  - Clear ls_rdata to 0 and set last<=LS.
  - If N==1, stay in IDLE. Otherwise go to LS_BUSY with cnt=1.

LS_BUSY
- Each cycle issue byte cnt: mem_cs=1, mem_we=we, mem_addr=(addr+cnt) mod 2^AW, mem_wdata=next byte.
- When cnt==N-1, go to IDLE; otherwise cnt++.
- No grants are given in LS_BUSY. if_req waits.

Read assembly
- For every issued LS read byte, the next cycle does ls_rdata <= {ls_rdata[23:0], mem_rdata}.

ls_done timing
- ls_done=1 in the cycle after the last byte is issued, for both reads and writes.
- LS latency is therefore N cycles from grant to done, with done at T+N.
- A new grant (IF or LS) may be issued in the same cycle as ls_done. ls_rdata updates for that new transfer begin no earlier than the following cycle.

Other rules
- Simultaneous requests from IDLE strictly alternate IF/LS.
- ls_req/if_req dropped before their grant: no effect, no error.
- Address wrap: addr+cnt is modulo 2^AW, so 0xFFFF + 1 → 0x0000 at AW=16.
- Writes: mem_rdata is ignored; ls_rdata stays 0.

Test Plan:
- Reset, IF only: rst low 2 cycles, then if_req=1 with if_addr=0x0010, 0x0011, 0x0012 on consecutive cycles, memory 0xA0/0xA1/0xA2 → if_gnt=1 each cycle; if_vld=1 with if_data 0xA0, 0xA1, 0xA2 one cycle later; busy=0 throughout.
- LS 4-byte read: ls_req, ls_we=0, ls_len=2, ls_addr=0x0100, mem bytes 0x12, 0x34, 0x56, 0x78 → mem_addr 0x100..0x103 on T..T+3; ls_done at T+4; ls_rdata=0x12345678.
- LS 2-byte write: ls_we=1, ls_len=1, ls_addr=0x0200, ls_wdata=0xDEADBEEF → (0x200, 0xBE) then (0x201, 0xEF) with mem_we=1; ls_done at T+2; ls_rdata=0.
- Contention: if_req and ls_req both held high from reset, ls_len=0 → grant order IF, LS, IF, LS…; no requester waits more than 1 LS transfer.
- Wrap and 1-byte read: ls_len=2, ls_addr=0xFFFE → mem_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001. Then ls_len=0 at 0x0005 with byte 0x9C → ls_rdata=0x0000009C and done at T+1.
- Reset mid-transfer: rst=0 during cnt=2 of a 4-byte read → mem_cs=0 that cycle, no ls_done, state IDLE; a following IF request is granted normally.
